bpf_biquad_prog: RTL and testbench

//  Second-order IIR bandpass (direct form I) with run-time programmable coefficients, parametrised widths,

---
 rtl/bpf_pkg.sv | 27 ++
 rtl/bpf_coef_bank.sv | 68 ++++++
 rtl/bpf_biquad_prog.sv | 131 +++++++++++++
 tb/tb_bpf_biquad_prog.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpf_pkg.sv
// rtl/bpf_pkg.sv - coefficient addresses and saturation helper shared by the bandpass biquad
package bpf_pkg;

  localparam int N_COEF = 5;

  localparam logic [2:0] C_B0 = 3'd0;
  localparam logic [2:0] C_B1 = 3'd1;
  localparam logic [2:0] C_B2 = 3'd2;
  localparam logic [2:0] C_A1 = 3'd3;
  localparam logic [2:0] C_A2 = 3'd4;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/bpf_coef_bank.sv
// rtl/bpf_coef_bank.sv - shadow/active coefficient registers with write-into-commit forwarding
module bpf_coef_bank
  import bpf_pkg::*;
#(
  parameter int COEF_W = 12,
  parameter int B0     = 9,
  parameter int B1     = 0,
  parameter int B2     = -9,
  parameter int A1     = 457,
  parameter int A2     = 238
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_wr,
  input  logic [2:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_commit,
  output logic signed [COEF_W-1:0] b0,
  output logic signed [COEF_W-1:0] b1,
  output logic signed [COEF_W-1:0] b2,
  output logic signed [COEF_W-1:0] a1,
  output logic signed [COEF_W-1:0] a2
);

  logic signed [COEF_W-1:0] defaults   [N_COEF];
  logic signed [COEF_W-1:0] shadow     [N_COEF];
  logic signed [COEF_W-1:0] shadow_nxt [N_COEF];
  logic signed [COEF_W-1:0] active     [N_COEF];

  assign defaults[C_B0] = COEF_W'(B0);
  assign defaults[C_B1] = COEF_W'(B1);
  assign defaults[C_B2] = COEF_W'(B2);
  assign defaults[C_A1] = COEF_W'(A1);
  assign defaults[C_A2] = COEF_W'(A2);

  // A write on the commit edge lands in shadow_nxt, so the commit picks it up.
  always_comb begin
    for (int i = 0; i < N_COEF; i++) begin
      shadow_nxt[i] = shadow[i];
    end
    if (coef_wr && (coef_addr <= C_A2)) begin
      shadow_nxt[coef_addr] = coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_COEF; i++) begin
        shadow[i] <= defaults[i];
        active[i] <= defaults[i];
      end
    end else begin
      for (int i = 0; i < N_COEF; i++) begin
        shadow[i] <= shadow_nxt[i];
        if (coef_commit) begin
          active[i] <= shadow_nxt[i];
        end
      end
    end
  end

  assign b0 = active[C_B0];
  assign b1 = active[C_B1];
  assign b2 = active[C_B2];
  assign a1 = active[C_A1];
  assign a2 = active[C_A2];

endmodule

// File: rtl/bpf_biquad_prog.sv
// rtl/bpf_biquad_prog.sv - programmable direct-form-I bandpass biquad with saturation, sticky ovf and settle flag
module bpf_biquad_prog
  import bpf_pkg::*;
#(
  parameter int IN_W   = 13,
  parameter int OUT_W  = 14,
  parameter int COEF_W = 12,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 22,
  parameter int SETTLE = 16,
  parameter int B0     = 9,
  parameter int B1     = 0,
  parameter int B2     = -9,
  parameter int A1     = 457,
  parameter int A2     = 238
) (
  input  logic                     clk325kHz,
  input  logic                     rst_n,
  input  logic signed [IN_W-1:0]   in,
  input  logic                     coef_wr,
  input  logic [2:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_commit,
  input  logic                     ovf_clr,
  output logic signed [OUT_W-1:0]  out,
  output logic signed [OUT_W-1:0]  out_inter,
  output logic                     out_valid,
  output logic                     ovf
);

  localparam int PROD_W = ACC_W + COEF_W + 2;
  localparam int CNT_W  = $clog2(SETTLE + 1);

  logic signed [COEF_W-1:0] b0, b1, b2, a1, a2;

  logic signed [IN_W-1:0]   x1, x2;
  logic signed [ACC_W-1:0]  y1, y2;
  logic signed [PROD_W-1:0] p_b0, p_b1, p_b2, p_a1, p_a2, acc;
  logic signed [63:0]       acc_sat, out_sat, inter_sat;
  logic signed [ACC_W-1:0]  y_new, y_shift;
  logic signed [ACC_W:0]    y_sum, sum_shift;
  logic                     state_clamp, out_clamp, inter_clamp, ovf_event;
  logic [CNT_W-1:0]         settle_cnt;

  bpf_coef_bank #(
    .COEF_W (COEF_W),
    .B0     (B0),
    .B1     (B1),
    .B2     (B2),
    .A1     (A1),
    .A2     (A2)
  ) u_coef_bank (
    .clk         (clk325kHz),
    .rst_n       (rst_n),
    .coef_wr     (coef_wr),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .a1          (a1),
    .a2          (a2)
  );

  // All operands are widened before multiplying so no product bits are lost;
  // feedback terms are floored back to the y scale before summing.
  always_comb begin
    p_b0        = PROD_W'(b0) * PROD_W'(in);
    p_b1        = PROD_W'(b1) * PROD_W'(x1);
    p_b2        = PROD_W'(b2) * PROD_W'(x2);
    p_a1        = (PROD_W'(a1) * PROD_W'(y1)) >>> FRAC;
    p_a2        = (PROD_W'(a2) * PROD_W'(y2)) >>> FRAC;
    acc         = p_b0 + p_b1 + p_b2 + p_a1 - p_a2;

    acc_sat     = sat(64'(acc), ACC_W);
    state_clamp = (acc_sat != 64'(acc));
    y_new       = acc_sat[ACC_W-1:0];

    y_shift     = y_new >>> FRAC;
    out_sat     = sat(64'(y_shift), OUT_W);
    out_clamp   = (out_sat != 64'(y_shift));

    y_sum       = (ACC_W+1)'(y_new) + (ACC_W+1)'(y1);
    sum_shift   = y_sum >>> (FRAC + 1);
    inter_sat   = sat(64'(sum_shift), OUT_W);
    inter_clamp = (inter_sat != 64'(sum_shift));

    ovf_event   = state_clamp | out_clamp | inter_clamp;
  end

  always_ff @(posedge clk325kHz or negedge rst_n) begin
    if (!rst_n) begin
      x1         <= '0;
      x2         <= '0;
      y1         <= '0;
      y2         <= '0;
      out        <= '0;
      out_inter  <= '0;
      settle_cnt <= '0;
      ovf        <= 1'b0;
    end else if (coef_commit) begin
      // New coefficients start from a clean history; ovf is left for software to clear.
      x1         <= '0;
      x2         <= '0;
      y1         <= '0;
      y2         <= '0;
      out        <= '0;
      out_inter  <= '0;
      settle_cnt <= '0;
    end else begin
      x1        <= in;
      x2        <= x1;
      y1        <= y_new;
      y2        <= y1;
      out       <= out_sat[OUT_W-1:0];
      out_inter <= inter_sat[OUT_W-1:0];
      if (settle_cnt < CNT_W'(SETTLE)) begin
        settle_cnt <= settle_cnt + CNT_W'(1);
      end
      if (ovf_event) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign out_valid = (settle_cnt == CNT_W'(SETTLE));

endmodule

// File: tb/tb_bpf_biquad_prog.sv
// tb/tb_bpf_biquad_prog.sv - self-checking bench for bpf_biquad_prog
module tb_bpf_biquad_prog;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [12:0] din;
  logic               coef_wr;
  logic [2:0]         coef_addr;
  logic signed [11:0] coef_data;
  logic               coef_commit;
  logic               ovf_clr;
  logic signed [13:0] out;
  logic signed [13:0] out_inter;
  logic               out_valid;
  logic               ovf;

  always #5 clk = ~clk;

  bpf_biquad_prog dut (
    .clk325kHz   (clk),
    .rst_n       (rst_n),
    .in          (din),
    .coef_wr     (coef_wr),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
    .ovf_clr     (ovf_clr),
    .out         (out),
    .out_inter   (out_inter),
    .out_valid   (out_valid),
    .ovf         (ovf)
  );

  typedef struct {
    longint o;
    longint inter;
    bit     valid;
    bit     ovf;
  } exp_t;

  typedef struct {
    int din;
    bit wr;
    int addr;
    int data;
    bit commit;
    bit chk;
    int e_out;
    int e_inter;
  } vec_t;

  exp_t   sb[$];
  vec_t   vt[11];
  int     checks   = 0;
  int     failures = 0;
  string  tag      = "init";

  longint m_s[5];
  longint m_a[5];
  longint mx1, mx2, my1, my2;
  bit     m_ovf;
  int     m_cnt;

  function automatic longint fsat(input longint v, input int w);
    longint hi;
    hi = (longint'(1) <<< (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s %s actual=%0d expected=%0d", tag, name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s   = '{9, 0, -9, 457, 238};
    m_a   = '{9, 0, -9, 457, 238};
    mx1   = 0;
    mx2   = 0;
    my1   = 0;
    my2   = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
    sb.delete();
  endtask

  task automatic model_step(input int xin, input bit wr, input int addr, input int data,
                            input bit commit, input bit clr);
    longint acc, y, ys, os, yi, is_v;
    bit     ev;
    exp_t   e;
    if (wr && addr >= 0 && addr < 5) m_s[addr] = data;
    if (commit) begin
      m_a   = m_s;
      mx1   = 0;
      mx2   = 0;
      my1   = 0;
      my2   = 0;
      m_cnt = 0;
      e.o     = 0;
      e.inter = 0;
    end else begin
      acc  = m_a[0] * xin + m_a[1] * mx1 + m_a[2] * mx2
           + ((m_a[3] * my1) >>> 8) - ((m_a[4] * my2) >>> 8);
      y    = fsat(acc, 22);
      ys   = y >>> 8;
      os   = fsat(ys, 14);
      yi   = (y + my1) >>> 9;
      is_v = fsat(yi, 14);
      ev   = (y != acc) || (os != ys) || (is_v != yi);
      if (ev) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      mx2 = mx1;
      mx1 = xin;
      my2 = my1;
      my1 = y;
      if (m_cnt < 16) m_cnt++;
      e.o     = os;
      e.inter = is_v;
    end
    e.valid = (m_cnt == 16);
    e.ovf   = m_ovf;
    sb.push_back(e);
  endtask

  task automatic step(input int xin, input bit wr, input int addr, input int data,
                      input bit commit, input bit clr);
    exp_t e;
    din         = 13'(xin);
    coef_wr     = wr;
    coef_addr   = 3'(addr);
    coef_data   = 12'(data);
    coef_commit = commit;
    ovf_clr     = clr;
    model_step(xin, wr, addr, data, commit, clr);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard actual=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk("out", out, e.o);
      chk("out_inter", out_inter, e.inter);
      chk("out_valid", out_valid, e.valid);
      chk("ovf", ovf, e.ovf);
    end
  endtask

  function automatic int rnd_in();
    return int'($urandom_range(100)) - 50;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{0,    1'b0, 0, 0,    1'b1, 1'b1, 0,  0};
    vt[1]  = '{0,    1'b1, 3, 300,  1'b0, 1'b1, 0,  0};
    vt[2]  = '{1000, 1'b0, 0, 0,    1'b0, 1'b1, 35, 17};
    vt[3]  = '{0,    1'b0, 0, 0,    1'b0, 1'b1, 62, 48};
    vt[4]  = '{0,    1'b1, 3, 300,  1'b1, 1'b1, 0,  0};
    vt[5]  = '{1000, 1'b0, 0, 0,    1'b0, 1'b1, 35, 17};
    vt[6]  = '{0,    1'b0, 0, 0,    1'b0, 1'b1, 41, 38};
    vt[7]  = '{0,    1'b1, 6, 1000, 1'b1, 1'b1, 0,  0};
    vt[8]  = '{1000, 1'b0, 0, 0,    1'b0, 1'b1, 35, 17};
    vt[9]  = '{0,    1'b0, 0, 0,    1'b0, 1'b1, 41, 38};
    vt[10] = '{0,    1'b0, 0, 0,    1'b0, 1'b0, 0,  0};

    rst_n       = 1'b0;
    din         = '0;
    coef_wr     = 1'b0;
    coef_addr   = '0;
    coef_data   = '0;
    coef_commit = 1'b0;
    ovf_clr     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tag = "reset";
    chk("out", out, 0);
    chk("out_inter", out_inter, 0);
    chk("out_valid", out_valid, 0);
    chk("ovf", ovf, 0);
    #2 rst_n = 1'b1;

    tag = "settle";
    for (int i = 1; i <= 40; i++) begin
      step((i <= 16) ? 0 : rnd_in(), 1'b0, 0, 0, (i == 40), 1'b0);
      if (i == 15) chk("valid_edge15", out_valid, 0);
      if (i == 16) chk("valid_edge16", out_valid, 1);
      if (i == 40) begin
        chk("commit_out", out, 0);
        chk("commit_valid", out_valid, 0);
      end
    end
    tag = "commit2";
    step(rnd_in(), 1'b0, 0, 0, 1'b1, 1'b0);
    chk("commit2_out", out, 0);
    for (int i = 1; i <= 16; i++) begin
      step(rnd_in(), 1'b0, 0, 0, 1'b0, 1'b0);
      if (i == 15) chk("resettle15", out_valid, 0);
      if (i == 16) chk("resettle16", out_valid, 1);
    end

    tag = "dc";
    step(0, 1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) step(100, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("dc_out_near_zero", (out >= -1 && out <= 0), 1);
    chk("dc_ovf", ovf, 0);

    for (int i = 0; i < 11; i++) begin
      tag = $sformatf("vec%0d", i);
      step(vt[i].din, vt[i].wr, vt[i].addr, vt[i].data, vt[i].commit, 1'b0);
      if (vt[i].chk) begin
        chk("tbl_out", out, vt[i].e_out);
        chk("tbl_inter", out_inter, vt[i].e_inter);
      end
    end

    tag = "sat";
    step(0, 1'b1, 0, 2047, 1'b0, 1'b0);
    step(0, 1'b1, 3, 511, 1'b0, 1'b0);
    step(0, 1'b1, 4, 0, 1'b1, 1'b0);
    step(4095, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("sat_first_out", out, 8191);
    chk("sat_first_ovf", ovf, 1);
    for (int i = 0; i < 5; i++) step(4095, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("sat_hold_out", out, 8191);
    step(4095, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("clr_vs_set", ovf, 1);
    step(0, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("commit_keeps_ovf", ovf, 1);
    step(0, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("clr_quiet", ovf, 0);
    step(4095, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("reoverflow", ovf, 1);
    step(0, 1'b1, 3, 300, 1'b0, 1'b0);

    tag = "areset";
    #2 rst_n = 1'b0;
    #1;
    chk("out", out, 0);
    chk("out_inter", out_inter, 0);
    chk("out_valid", out_valid, 0);
    chk("ovf", ovf, 0);
    #1 rst_n = 1'b1;
    model_reset();
    step(0, 1'b0, 0, 0, 1'b1, 1'b0);
    step(1000, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("default_out0", out, 35);
    chk("default_inter0", out_inter, 17);
    step(0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("default_out1", out, 62);
    chk("default_inter1", out_inter, 48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
